sat_error_subber: RTL and testbench

SAT_ERROR_SUBBER -- requirements
Module: sat_error_subber

---
 rtl/sat_error_subber.sv | 174 +++++++++++++++++
 tb/tb_sat_error_subber.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_error_subber.sv
// sat_error_subber: per-channel setpoint subtractor with saturation.
// Two-stage pipeline:
//   stage 1 registers data_in - setpoint at NUM_BITS+1 bits;
//   stage 2 clamps to the NUM_BITS signed range and registers the outputs.
// The optional deadband zeroing is enabled by defining SAT_ERR_DEADBAND_EN.
// With the macro undefined, the deadband port is ignored.
module sat_error_subber #(
    parameter int NUM_BITS = 32,
    parameter int NUM_CH   = 4,
    parameter int CH_BITS  = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_en,
    input  logic [CH_BITS-1:0]  data_ch,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                sp_wr_en,
    input  logic [CH_BITS-1:0]  sp_wr_ch,
    input  logic [NUM_BITS-1:0] sp_wr_data,
    input  logic [NUM_BITS-1:0] deadband,
    input  logic                sat_clr,
    output logic [NUM_BITS-1:0] data_out,
    output logic [CH_BITS-1:0]  data_ch_out,
    output logic                data_en_out,
    output logic                sat_out,
    output logic [15:0]         sat_count
);

    localparam logic [CH_BITS:0]    NUM_CH_W = NUM_CH[CH_BITS:0];
    localparam logic [NUM_BITS-1:0] MAX_VAL  = {1'b0, {(NUM_BITS-1){1'b1}}};
    localparam logic [NUM_BITS-1:0] MIN_VAL  = {1'b1, {(NUM_BITS-1){1'b0}}};

    // ---------------------------------------------------------------
    // Setpoint bank
    // ---------------------------------------------------------------
    logic [NUM_BITS-1:0] sp_rd [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sp
        logic [NUM_BITS-1:0] sp_q;

        // Each entry loads only when its own channel is addressed.
        // Out-of-range write channels therefore match no entry.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sp_q <= '0;
            end else if (sp_wr_en && ({1'b0, sp_wr_ch} == CH_BITS'(gi) + (CH_BITS+1)'(0))) begin
                sp_q <= sp_wr_data;
            end
        end

        assign sp_rd[gi] = sp_q;
    end

    // ---------------------------------------------------------------
    // Stage 1: subtraction at NUM_BITS+1 bits (cannot overflow)
    // ---------------------------------------------------------------
    logic                ch_ok;
    logic [CH_BITS-1:0]  rd_idx;
    logic [NUM_BITS-1:0] sp_sel;
    logic [NUM_BITS:0]   diff_d;

    // Out-of-range sample channels read the channel-0 setpoint.
    // The tag still carries the original channel number.
    // The bank is read before this edge's write lands, so a coincident
    // write is seen only by the following samples.
    always_comb begin
        ch_ok  = ({1'b0, data_ch} < NUM_CH_W);
        rd_idx = ch_ok ? data_ch : '0;
        sp_sel = sp_rd[rd_idx];
        diff_d = {data_in[NUM_BITS-1], data_in} - {sp_sel[NUM_BITS-1], sp_sel};
    end

    logic                s1_valid_q;
    logic [NUM_BITS:0]   s1_diff_q;
    logic [CH_BITS-1:0]  s1_ch_q;

    // The stage-1 valid flag is cleared by reset, so samples already in
    // flight when reset asserts are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_ch_q    <= '0;
        end else begin
            s1_valid_q <= data_en;
            if (data_en) begin
                s1_diff_q <= diff_d;
                s1_ch_q   <= data_ch;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: clamp (plus optional deadband)
    // ---------------------------------------------------------------
    logic                ovf_d;
    logic [NUM_BITS-1:0] clamp_d;
    logic [NUM_BITS-1:0] result_d;

    // Overflow shows up as the top two bits of the wide difference
    // disagreeing; the sign bit then picks which rail to use.
    always_comb begin
        ovf_d   = s1_diff_q[NUM_BITS] ^ s1_diff_q[NUM_BITS-1];
        clamp_d = ovf_d ? (s1_diff_q[NUM_BITS] ? MIN_VAL : MAX_VAL)
                        : s1_diff_q[NUM_BITS-1:0];
    end

`ifdef SAT_ERR_DEADBAND_EN
    logic [NUM_BITS-1:0] mag_d;

    // The magnitude is read as unsigned, so abs(MIN) = 2^(NUM_BITS-1)
    // still fits. The deadband is applied to the value after clamping.
    always_comb begin
        mag_d    = clamp_d[NUM_BITS-1] ? (~clamp_d + 1'b1) : clamp_d;
        result_d = (mag_d <= deadband) ? '0 : clamp_d;
    end
`else
    logic unused_deadband;

    // Deadband is not used in this build.
    always_comb begin
        unused_deadband = ^deadband;
        result_d        = clamp_d;
    end
`endif

    logic                data_en_out_q;
    logic                sat_out_q;
    logic [NUM_BITS-1:0] data_out_q;
    logic [CH_BITS-1:0]  data_ch_out_q;

    // Output register.
    // The data and the tag hold their last values when no valid result
    // arrives. The valid and saturation flags are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_en_out_q <= 1'b0;
            sat_out_q     <= 1'b0;
            data_out_q    <= '0;
            data_ch_out_q <= '0;
        end else begin
            data_en_out_q <= s1_valid_q;
            sat_out_q     <= s1_valid_q & ovf_d;
            if (s1_valid_q) begin
                data_out_q    <= result_d;
                data_ch_out_q <= s1_ch_q;
            end
        end
    end

    // ---------------------------------------------------------------
    // Saturation counter
    // ---------------------------------------------------------------
    logic [15:0] sat_count_q;

    // The counter updates on the same edge that registers sat_out.
    // It sticks at all-ones, and a clear takes priority over a clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else if (sat_clr) begin
            sat_count_q <= '0;
        end else if (s1_valid_q && ovf_d && (sat_count_q != 16'hFFFF)) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign data_out    = data_out_q;
    assign data_ch_out = data_ch_out_q;
    assign data_en_out = data_en_out_q;
    assign sat_out     = sat_out_q;
    assign sat_count   = sat_count_q;

endmodule

// File: tb/tb_sat_error_subber.sv
// Directed testbench for sat_error_subber (NUM_BITS=8, NUM_CH=4).
// Inputs change 1 ns after each rising edge.
// Outputs are sampled at that same point, before the next edge.
module tb_sat_error_subber;

    localparam int NB = 8;
    localparam int NC = 4;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_en;
    logic [CB-1:0] data_ch;
    logic [NB-1:0] data_in;
    logic          sp_wr_en;
    logic [CB-1:0] sp_wr_ch;
    logic [NB-1:0] sp_wr_data;
    logic [NB-1:0] deadband;
    logic          sat_clr;
    logic [NB-1:0] data_out;
    logic [CB-1:0] data_ch_out;
    logic          data_en_out;
    logic          sat_out;
    logic [15:0]   sat_count;

    int checks   = 0;
    int failures = 0;

    sat_error_subber #(.NUM_BITS(NB), .NUM_CH(NC), .CH_BITS(CB)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_en     (data_en),
        .data_ch     (data_ch),
        .data_in     (data_in),
        .sp_wr_en    (sp_wr_en),
        .sp_wr_ch    (sp_wr_ch),
        .sp_wr_data  (sp_wr_data),
        .deadband    (deadband),
        .sat_clr     (sat_clr),
        .data_out    (data_out),
        .data_ch_out (data_ch_out),
        .data_en_out (data_en_out),
        .sat_out     (sat_out),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic en, input int ch, input int val);
        data_en = en;
        data_ch = CB'(ch);
        data_in = NB'(val);
    endtask

    // Checks the registered outputs; expected data is a signed value.
    task automatic check_out(input string tag, input int exp_data, input int exp_ch,
                             input int exp_en, input int exp_sat);
        check_val({tag, ".data"}, int'($signed(data_out)), exp_data);
        check_val({tag, ".ch"},   int'(data_ch_out),       exp_ch);
        check_val({tag, ".en"},   int'(data_en_out),       exp_en);
        check_val({tag, ".sat"},  int'(sat_out),           exp_sat);
    endtask

    initial begin
        rst        = 1'b1;
        data_en    = 1'b0;
        data_ch    = '0;
        data_in    = '0;
        sp_wr_en   = 1'b0;
        sp_wr_ch   = '0;
        sp_wr_data = '0;
        deadband   = '0;
        sat_clr    = 1'b0;
        tick();
        tick();
        check_out("reset", 0, 0, 0, 0);
        check_val("reset.cnt", int'(sat_count), 0);
        rst = 1'b0;
        tick();

        // Basic subtract: sp[2]=10, ch2 sample 25 -> 15.
        sp_wr_en = 1'b1; sp_wr_ch = 2'd2; sp_wr_data = 8'd10;
        tick();
        sp_wr_en = 1'b0;
        drive_sample(1'b1, 2, 25);
        tick();
        drive_sample(1'b0, 0, 0);
        check_val("basic.lat1.en", int'(data_en_out), 0);
        tick();
        check_out("basic", 15, 2, 1, 0);
        tick();
        check_out("basic.hold", 15, 2, 0, 0);

        // Positive clamp: sp[1]=-100, sample 100 -> 127.
        sp_wr_en = 1'b1; sp_wr_ch = 2'd1; sp_wr_data = NB'(-100);
        tick();
        sp_wr_en = 1'b0;
        drive_sample(1'b1, 1, 100);
        tick();
        drive_sample(1'b0, 0, 0);
        tick();
        check_out("satpos", 127, 1, 1, 1);
        check_val("satpos.cnt", int'(sat_count), 1);

        // Negative clamp: sp[1]=100, sample -100 -> -128.
        sp_wr_en = 1'b1; sp_wr_ch = 2'd1; sp_wr_data = 8'd100;
        tick();
        sp_wr_en = 1'b0;
        drive_sample(1'b1, 1, -100);
        tick();
        drive_sample(1'b0, 0, 0);
        tick();
        check_out("satneg", -128, 1, 1, 1);
        check_val("satneg.cnt", int'(sat_count), 2);

        // Clear coincident with a clamped result: clear wins.
        drive_sample(1'b1, 1, -100);
        tick();
        drive_sample(1'b0, 0, 0);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check_val("clr.sat", int'(sat_out), 1);
        check_val("clr.cnt", int'(sat_count), 0);

        // The count resumes from zero after the clear.
        drive_sample(1'b1, 1, -100);
        tick();
        drive_sample(1'b0, 0, 0);
        tick();
        check_val("clr.recount", int'(sat_count), 1);

        // A sample coincident with a setpoint write on the same channel
        // uses the old setpoint.
        sp_wr_en = 1'b1; sp_wr_ch = 2'd0; sp_wr_data = 8'd50;
        drive_sample(1'b1, 0, 60);
        tick();
        sp_wr_en = 1'b0;
        drive_sample(1'b1, 0, 60);
        tick();
        drive_sample(1'b0, 0, 0);
        check_out("wrsame.old", 60, 0, 1, 0);
        tick();
        check_out("wrsame.new", 10, 0, 1, 0);

        // Back-to-back samples on all channels.
        // Setpoints are now sp0=50, sp1=100, sp2=10, sp3=0.
        drive_sample(1'b1, 0, 51);
        tick();
        drive_sample(1'b1, 1, 102);
        tick();
        check_out("b2b0", 1, 0, 1, 0);
        drive_sample(1'b1, 2, 13);
        tick();
        check_out("b2b1", 2, 1, 1, 0);
        drive_sample(1'b1, 3, 4);
        tick();
        check_out("b2b2", 3, 2, 1, 0);
        drive_sample(1'b0, 0, 0);
        tick();
        check_out("b2b3", 4, 3, 1, 0);
        tick();
        check_val("b2b.idle.en", int'(data_en_out), 0);

        // Reset asserted mid-stream discards the samples in flight.
        drive_sample(1'b1, 0, 51);
        tick();
        drive_sample(1'b1, 1, 102);
        tick();
        drive_sample(1'b1, 2, 13);
        #1 rst = 1'b1;
        #1;
        check_out("rstmid", 0, 0, 0, 0);
        check_val("rstmid.cnt", int'(sat_count), 0);
        drive_sample(1'b0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        check_val("rstpost.en1", int'(data_en_out), 0);
        tick();
        check_val("rstpost.en2", int'(data_en_out), 0);

        // Setpoints read as zero after reset: ch2 sample 7 -> 7.
        drive_sample(1'b1, 2, 7);
        tick();
        drive_sample(1'b0, 0, 0);
        tick();
        check_out("rstsp", 7, 2, 1, 0);

        // Deadband of 5 applied to errors 4, -5 and 6.
        // All setpoints are 0, so each error equals the sample.
        deadband = 8'd5;
        drive_sample(1'b1, 3, 4);
        tick();
        drive_sample(1'b1, 3, -5);
        tick();
`ifdef SAT_ERR_DEADBAND_EN
        check_out("db4", 0, 3, 1, 0);
`else
        check_out("db4", 4, 3, 1, 0);
`endif
        drive_sample(1'b1, 3, 6);
        tick();
`ifdef SAT_ERR_DEADBAND_EN
        check_out("dbm5", 0, 3, 1, 0);
`else
        check_out("dbm5", -5, 3, 1, 0);
`endif
        drive_sample(1'b0, 0, 0);
        tick();
        check_out("db6", 6, 3, 1, 0);
        deadband = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog for a runaway simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
